dec2bin_ctrl: RTL and testbench
===============================

DEC2BIN_CTRL -- requirements
Module: dec2bin_ctrl

Interface
REQ-001 SHALL have parameter ND, default 4, meaning number of BCD digits per conversion (ND>=1).
REQ-002 SHALL have parameter W, default 16, meaning signed result width in bits (W>=5).
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin conversion; sampled only in IDLE.
REQ-006 SHALL have port neg  input  1  sign of the number; captured with start.
REQ-007 SHALL have port digit  input  4  BCD digit, most-significant digit first.
REQ-008 SHALL have port digit_valid  input  1  digit is presented.
REQ-009 SHALL have port digit_ready  output  1  controller accepts a digit this cycle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result and err are final.
REQ-012 SHALL have port err  output  1  invalid digit or overflow in the last conversion.
REQ-013 SHALL have port result  output  W  signed two's-complement conversion result.

Function
REQ-014 SHALL implement the states IDLE, WAIT, FIN and DONE, all registered.
REQ-015 SHALL, in IDLE with start=1: clear acc to 0, cnt to 0 and err to 0, latch neg, and go to WAIT.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL drive digit_ready=1 only in WAIT; a digit is accepted on an edge where digit_valid and digit_ready are both high.
REQ-018 SHALL, on each accepted digit, update acc <= (acc<<3)+(acc<<1)+digit, computed at width W+4 with no truncation before the overflow check; cnt is incremented.
REQ-019 SHALL treat an accepted digit greater than 9 as invalid: set err, leave acc unchanged and go to FIN immediately.
REQ-020 SHALL set err sticky (overflow) when the W+4-bit magnitude exceeds 2^(W-1)-1 with neg=0, or exceeds 2^(W-1) with neg=1; conversion continues and consumes all ND digits.
REQ-021 SHALL go from WAIT to FIN on the edge that accepts digit number ND (cnt=ND-1).
REQ-022 SHALL, in FIN (one cycle): register result as 0 if err=1, else as -acc if neg=1, else as acc (low W bits); then go to DONE.
REQ-023 SHALL, in DONE (one cycle): assert done=1 and return to IDLE.
REQ-024 SHALL give done two cycles after the accepting edge of the last digit: FIN in the next cycle, then DONE.
REQ-025 SHALL hold result and err stable from DONE until the next accepted start.
REQ-026 SHALL stall indefinitely in WAIT while digit_valid=0, with no timeout.
REQ-027 SHALL keep busy=1 in WAIT, FIN and DONE, and busy=0 in IDLE.

Reset
REQ-028 SHALL, on rst_n=0 in any state (including mid-conversion), go to IDLE asynchronously with acc=0, cnt=0, result=0, err=0, done=0, digit_ready=0 and busy=0.
REQ-029 SHALL discard a partially converted value on reset and SHALL NOT assert done for it.

Verification
REQ-030 SHALL cover: ND=4, W=16, neg=0, digits 1,2,3,4 -> done 2 cycles after the 4th accept, result=16'd1234 (0x04D2), err=0.
REQ-031 SHALL cover: neg=1, digits 0,0,4,2 with one idle cycle of digit_valid=0 between them -> result=0xFFD6 (-42), err=0; digit_ready stays high while stalled.
REQ-032 SHALL cover: digits 3,0xA -> second digit sets err, FIN follows immediately, result=0, err=1, done pulses once.
REQ-033 SHALL cover: ND=3, W=8, digits 1,2,8 -> neg=0 gives err=1 and result=0; neg=1 gives err=0 and result=0x80 (-128).
REQ-034 SHALL cover: start pulsed while busy -> ignored with no state change; rst_n dropped after 2 accepted digits -> immediate IDLE with all outputs 0 and no done, and a following fresh conversion of 9,9,9,9 -> 9999.

Source files
------------

// File: rtl/dec2bin_ctrl.sv
// Serial BCD-to-binary converter: accepts ND digits MSD-first and produces a
// signed W-bit result, flagging invalid digits and range overflow in err.
module dec2bin_ctrl #(
  parameter int ND = 4,
  parameter int W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         neg,
  input  logic [3:0]   digit,
  input  logic         digit_valid,
  output logic         digit_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  // Largest magnitude representable for each sign, at the widened W+4 width.
  localparam logic [W+3:0] LIM_POS = {5'b0, {(W-1){1'b1}}};
  localparam logic [W+3:0] LIM_NEG = {4'b0, 1'b1, {(W-1){1'b0}}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic          neg_q;

  logic [W+3:0]  acc_x;
  logic [W+3:0]  next_x;
  logic [W+3:0]  lim;
  logic          ovf;
  logic          accept;
  logic          last;

  // Handshake: a digit transfers on a rising edge where digit_valid and
  // digit_ready are both high; digit_ready is high only in WAIT and the
  // controller waits indefinitely for digit_valid.
  always_comb begin
    acc_x  = {4'b0, acc};
    next_x = (acc_x << 3) + (acc_x << 1) + {{W{1'b0}}, digit};
    lim    = neg_q ? LIM_NEG : LIM_POS;
    ovf    = (next_x > lim);
    accept = digit_valid && digit_ready;
    last   = (cnt == CW'(ND - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      digit_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            neg_q       <= neg;
            state       <= WAIT;
            busy        <= 1'b1;
            digit_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (accept) begin
            if (digit > 4'd9) begin
              err         <= 1'b1;
              state       <= FIN;
              digit_ready <= 1'b0;
            end else begin
              // Once overflowed, err is sticky so the truncated acc never matters.
              acc <= next_x[W-1:0];
              cnt <= cnt + CW'(1);
              if (ovf) err <= 1'b1;
              if (last) begin
                state       <= FIN;
                digit_ready <= 1'b0;
              end
            end
          end
        end
        FIN: begin
          result <= err ? '0 : (neg_q ? (W'(0) - acc) : acc);
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dec2bin_ctrl.sv
// Directed bench for dec2bin_ctrl: a 4-digit/16-bit instance and a
// 3-digit/8-bit instance, checked with immediate assertions.
module tb_dec2bin_ctrl;

  logic clk;
  logic rst_n;

  logic        a_start, a_neg, a_valid, a_ready, a_busy, a_done, a_err;
  logic [3:0]  a_digit;
  logic [15:0] a_result;
  logic [1:0]  a_dbg;

  logic        b_start, b_neg, b_valid, b_ready, b_busy, b_done, b_err;
  logic [3:0]  b_digit;
  logic [7:0]  b_result;
  logic [1:0]  b_dbg;

  int checks = 0;
  int errors = 0;

  dec2bin_ctrl #(.ND(4), .W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .neg(a_neg), .digit(a_digit),
    .digit_valid(a_valid), .digit_ready(a_ready), .busy(a_busy), .done(a_done),
    .err(a_err), .result(a_result), .dbg_state(a_dbg)
  );

  dec2bin_ctrl #(.ND(3), .W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .neg(b_neg), .digit(b_digit),
    .digit_valid(b_valid), .digit_ready(b_ready), .busy(b_busy), .done(b_done),
    .err(b_err), .result(b_result), .dbg_state(b_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_ready(input bit sel);
    return sel ? {31'b0, b_ready} : {31'b0, a_ready};
  endfunction
  function automatic logic [31:0] get_busy(input bit sel);
    return sel ? {31'b0, b_busy} : {31'b0, a_busy};
  endfunction
  function automatic logic [31:0] get_done(input bit sel);
    return sel ? {31'b0, b_done} : {31'b0, a_done};
  endfunction
  function automatic logic [31:0] get_err(input bit sel);
    return sel ? {31'b0, b_err} : {31'b0, a_err};
  endfunction
  function automatic logic [31:0] get_result(input bit sel);
    return sel ? {24'b0, b_result} : {16'b0, a_result};
  endfunction

  // Driver tasks: all entered and left at a falling edge
  task automatic do_start(input bit sel, input logic n);
    if (sel) begin b_start = 1'b1; b_neg = n; end
    else     begin a_start = 1'b1; a_neg = n; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [3:0] d);
    int k = 0;
    while (get_ready(sel) !== 32'd1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_digit", get_ready(sel), 32'd1);
    if (sel) begin b_valid = 1'b1; b_digit = d; end
    else     begin a_valid = 1'b1; a_digit = d; end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Called one half-cycle after the last accepting edge (FIN state).
  task automatic finish(input bit sel, input string tag, input logic [31:0] exp_res,
                        input logic [31:0] exp_err);
    check({tag, "_fin_done"},  get_done(sel),  32'd0);
    check({tag, "_fin_ready"}, get_ready(sel), 32'd0);
    check({tag, "_fin_busy"},  get_busy(sel),  32'd1);
    @(negedge clk);
    check({tag, "_done"},      get_done(sel),   32'd1);
    check({tag, "_done_busy"}, get_busy(sel),   32'd1);
    check({tag, "_result"},    get_result(sel), exp_res);
    check({tag, "_err"},       get_err(sel),    exp_err);
    @(negedge clk);
    check({tag, "_idle_done"},   get_done(sel),   32'd0);
    check({tag, "_idle_busy"},   get_busy(sel),   32'd0);
    check({tag, "_hold_result"}, get_result(sel), exp_res);
    check({tag, "_hold_err"},    get_err(sel),    exp_err);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_neg = 1'b0; a_valid = 1'b0; a_digit = 4'd0;
    b_start = 1'b0; b_neg = 1'b0; b_valid = 1'b0; b_digit = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   get_busy(0),   32'd0);
    check("rst_ready",  get_ready(0),  32'd0);
    check("rst_done",   get_done(0),   32'd0);
    check("rst_err",    get_err(0),    32'd0);
    check("rst_result", get_result(0), 32'd0);
    check("rst_b_busy", get_busy(1),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1,2,3,4 positive -> 1234
    do_start(0, 1'b0);
    check("t1_busy",  get_busy(0),  32'd1);
    check("t1_ready", get_ready(0), 32'd1);
    send(0, 4'd1); send(0, 4'd2); send(0, 4'd3); send(0, 4'd4);
    finish(0, "t1", 32'h04D2, 32'd0);

    // 0,0,4,2 negative with stalls -> -42
    do_start(0, 1'b1);
    send(0, 4'd0);
    check("t2_stall_ready1", get_ready(0), 32'd1);
    @(negedge clk);
    send(0, 4'd0);
    check("t2_stall_ready2", get_ready(0), 32'd1);
    @(negedge clk);
    send(0, 4'd4);
    check("t2_stall_ready3", get_ready(0), 32'd1);
    @(negedge clk);
    send(0, 4'd2);
    finish(0, "t2", 32'hFFD6, 32'd0);

    // 3 then invalid 0xA -> immediate FIN, err, result 0
    do_start(0, 1'b0);
    send(0, 4'd3);
    send(0, 4'hA);
    finish(0, "t3", 32'h0000, 32'd1);
    @(negedge clk);
    check("t3_done_once", get_done(0),   32'd0);
    check("t3_stable",    get_result(0), 32'd0);

    // start and neg toggled mid-conversion must be ignored -> 5678
    do_start(0, 1'b0);
    send(0, 4'd5);
    a_start = 1'b1; a_neg = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_neg = 1'b0;
    check("t4_ign_busy",  get_busy(0),  32'd1);
    check("t4_ign_ready", get_ready(0), 32'd1);
    send(0, 4'd6); send(0, 4'd7); send(0, 4'd8);
    finish(0, "t4", 32'h162E, 32'd0);

    // Asynchronous reset after two accepted digits
    do_start(0, 1'b0);
    send(0, 4'd9); send(0, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",   get_busy(0),   32'd0);
    check("t5_rst_ready",  get_ready(0),  32'd0);
    check("t5_rst_result", get_result(0), 32'd0);
    check("t5_rst_err",    get_err(0),    32'd0);
    check("t5_rst_done",   get_done(0),   32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t5_rst_no_done", get_done(0), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_busy", get_busy(0), 32'd0);
    check("t5_post_done", get_done(0), 32'd0);
    do_start(0, 1'b0);
    send(0, 4'd9); send(0, 4'd9); send(0, 4'd9); send(0, 4'd9);
    finish(0, "t5", 32'h270F, 32'd0);

    // ND=3, W=8: 128 overflows positive, fits negative
    do_start(1, 1'b0);
    send(1, 4'd1); send(1, 4'd2); send(1, 4'd8);
    finish(1, "t6_pos", 32'h00, 32'd1);
    do_start(1, 1'b1);
    send(1, 4'd1); send(1, 4'd2); send(1, 4'd8);
    finish(1, "t6_neg", 32'h80, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
